// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//   ID-stage hazard detector for the 5-stage MIPS pipeline. Compares the IF/ID
//   source registers against the ID/EX and EX/MEM destinations and produces
//   the PC / IF/ID write enables, the bubble select for the control mux, and
//   the IF/ID flush for branches/jumps resolved in ID. A two-state FSM
//   (RUN/HOLD) stretches a branch-after-load-in-EX hazard to two stall cycles.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   IfId_Rs/Rt, IfId_UsesRt    ID instruction sources, rt-read qualifier
//   IfId_BranchOrJR            ID instruction compares registers in ID
//   IdEx_MemRead/RegWrite/WriteReg   EX instruction info
//   ExMem_MemRead/WriteReg     MEM instruction info
//   Branch_Taken               branch taken / jump decoded in ID
//   PCWrite, IfIdWrite         write enables (0 = stall)
//   Ctrl_Mux_Select_Stall      0 = inject bubble, 1 = pass control word
//   IfId_Flush                 zero IF/ID on the next edge
//   stall_cycles, flush_count  saturating statistics counters
//
// Build option: define HAZARD_STATS_EN to build the statistics counters;
// otherwise both statistics outputs are tied to zero.

module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IfId_Rs,
  input  logic [REG_ADDR_W-1:0] IfId_Rt,
  input  logic                  IfId_UsesRt,
  input  logic                  IfId_BranchOrJR,
  input  logic                  IdEx_MemRead,
  input  logic                  IdEx_RegWrite,
  input  logic [REG_ADDR_W-1:0] IdEx_WriteReg,
  input  logic                  ExMem_MemRead,
  input  logic [REG_ADDR_W-1:0] ExMem_WriteReg,
  input  logic                  Branch_Taken,
  output logic                  PCWrite,
  output logic                  IfIdWrite,
  output logic                  Ctrl_Mux_Select_Stall,
  output logic                  IfId_Flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic StRun  = 1'b0;
  localparam logic StHold = 1'b1;

  logic state_q, state_d;
  logic match_ex, match_mem;
  logic lu, ba, bl, bm;
  logic stall_now;

  // $0 is hardwired to zero, so a zero destination never creates a hazard.
  assign match_ex  = (IdEx_WriteReg != '0) &&
                     ((IdEx_WriteReg == IfId_Rs) || (IfId_UsesRt && (IdEx_WriteReg == IfId_Rt)));
  assign match_mem = (ExMem_WriteReg != '0) &&
                     ((ExMem_WriteReg == IfId_Rs) || (IfId_UsesRt && (ExMem_WriteReg == IfId_Rt)));

  assign lu = IdEx_MemRead && match_ex;
  assign ba = IfId_BranchOrJR && IdEx_RegWrite && !IdEx_MemRead && match_ex;
  assign bl = IfId_BranchOrJR && IdEx_MemRead && match_ex;
  assign bm = IfId_BranchOrJR && ExMem_MemRead && match_mem;

  // HOLD stalls unconditionally so the second BL cycle ignores input changes.
  assign stall_now = (state_q == StHold) || lu || ba || bl || bm;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bl) state_d = StHold;
      StHold:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // Enables are forced low while reset is held, independent of state.
  assign PCWrite               = !rst && !stall_now;
  assign IfIdWrite             = !rst && !stall_now;
  assign Ctrl_Mux_Select_Stall = !rst && !stall_now;
  // A flush is withheld during a stall; the branch is re-evaluated afterwards.
  assign IfId_Flush            = !rst && Branch_Taken && !stall_now;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_now && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (IfId_Flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
